// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode constants, opcode classes, immediate formats
// and the ID/EX register layout.
package cpu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOpimm   = 7'b0010011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpOpimm32 = 7'b0011011;
    localparam logic [6:0] OpOp32    = 7'b0111011;

    typedef enum logic [3:0] {
        OcIllegal = 4'd0,
        OcLui,
        OcAuipc,
        OcJal,
        OcJalr,
        OcBranch,
        OcLoad,
        OcStore,
        OcOpimm,
        OcOp,
        OcOpimm32,
        OcOp32
    } opclass_t;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            we;
        opclass_t        opclass;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            illegal;
    } idex_t;

    function automatic opclass_t decode_opclass(input logic [6:0] opcode);
        case (opcode)
            OpLui:     return OcLui;
            OpAuipc:   return OcAuipc;
            OpJal:     return OcJal;
            OpJalr:    return OcJalr;
            OpBranch:  return OcBranch;
            OpLoad:    return OcLoad;
            OpStore:   return OcStore;
            OpOpimm:   return OcOpimm;
            OpOp:      return OcOp;
            OpOpimm32: return OcOpimm32;
            OpOp32:    return OcOp32;
            default:   return OcIllegal;
        endcase
    endfunction

    function automatic imm_fmt_t imm_fmt(input opclass_t oc);
        case (oc)
            OcJalr, OcLoad, OcOpimm, OcOpimm32: return ImmI;
            OcStore:                            return ImmS;
            OcBranch:                           return ImmB;
            OcLui, OcAuipc:                     return ImmU;
            OcJal:                              return ImmJ;
            default:                            return ImmNone;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-bank, writeback and execute connections of the decode stage.
interface decode_stage_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic [cpu_pkg::XLEN-1:0] in_pc;
    logic [31:0]              rb_instruction;
    logic                     rb_read_en;
    logic [cpu_pkg::XLEN-1:0] rb_read_data1;
    logic [cpu_pkg::XLEN-1:0] rb_read_data2;
    logic                     wb_en;
    logic [4:0]               wb_rd;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [cpu_pkg::XLEN-1:0] out_pc;
    logic [cpu_pkg::XLEN-1:0] out_rs1_data;
    logic [cpu_pkg::XLEN-1:0] out_rs2_data;
    logic [cpu_pkg::XLEN-1:0] out_imm;
    logic [4:0]               out_rd;
    logic                     out_we;
    logic [3:0]               out_opclass;
    logic [2:0]               out_funct3;
    logic                     out_funct7b5;
    logic                     out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, rb_read_data1, rb_read_data2,
               wb_en, wb_rd, flush, out_ready,
        input  in_ready, rb_instruction, rb_read_en, out_valid, out_pc, out_rs1_data,
               out_rs2_data, out_imm, out_rd, out_we, out_opclass, out_funct3,
               out_funct7b5, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, rb_read_data1, rb_read_data2,
               wb_en, wb_rd, flush, out_ready,
        output in_ready, rb_instruction, rb_read_en, out_valid, out_pc, out_rs1_data,
               out_rs2_data, out_imm, out_rd, out_we, out_opclass, out_funct3,
               out_funct7b5, out_illegal
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV64I immediate extraction; every format sign-extends from instr[31].
module imm_gen
    import cpu_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic s;
    assign s = instr[31];

    always_comb begin
        imm = '0;
        case (fmt)
            ImmI: imm = {{(XLEN-12){s}}, instr[31:20]};
            ImmS: imm = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
            ImmB: imm = {{(XLEN-13){s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU: imm = {{(XLEN-32){s}}, instr[31:12], 12'b0};
            ImmJ: imm = {{(XLEN-21){s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: field decode, pending-write scoreboard with RAW stall,
// and the ID/EX pipeline register toward execute.
module decode_stage
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    decode_stage_if.slave bus
);

    logic [31:0]     instr;
    opclass_t        opclass;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1, rs2, rd;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic            hazard, issue;

    logic [31:0] sb_q, sb_d;
    logic        out_valid_q, out_valid_d;
    idex_t       idex_q, idex_d;

    assign instr   = bus.in_instr;
    assign opclass = decode_opclass(instr[6:0]);
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign rd      = instr[11:7];

    imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .fmt   (imm_fmt(opclass)),
        .imm   (imm)
    );

    always_comb begin
        uses_rs1  = !(opclass inside {OcLui, OcAuipc, OcJal, OcIllegal});
        uses_rs2  = opclass inside {OcBranch, OcStore, OcOp, OcOp32};
        writes_rd = !(opclass inside {OcBranch, OcStore, OcIllegal}) && (rd != 5'd0);
    end

    // The scoreboard is read before this cycle's writeback clear takes effect, so a
    // consumer keeps stalling through the wb_en cycle.
    assign hazard = bus.in_valid && ((uses_rs1 && sb_q[rs1]) || (uses_rs2 && sb_q[rs2]));
    assign bus.in_ready = !hazard && !bus.flush && (!out_valid_q || bus.out_ready);
    assign issue = bus.in_valid && bus.in_ready;

    assign bus.rb_instruction = instr;
    assign bus.rb_read_en     = bus.in_valid;

    always_comb begin
        sb_d = sb_q;
        if (bus.wb_en) sb_d[bus.wb_rd] = 1'b0;
        if (bus.flush && out_valid_q && idex_q.we) sb_d[idex_q.rd] = 1'b0;
        // Set after clear: the issuing instruction is younger than the retiring write.
        if (issue && writes_rd) sb_d[rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        idex_d      = idex_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            idex_d = '{
                pc:       bus.in_pc,
                rs1_data: bus.rb_read_data1,
                rs2_data: bus.rb_read_data2,
                imm:      imm,
                rd:       rd,
                we:       writes_rd,
                opclass:  opclass,
                funct3:   instr[14:12],
                funct7b5: instr[30],
                illegal:  (opclass == OcIllegal)
            };
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            out_valid_q <= 1'b0;
            idex_q      <= '0;
        end else begin
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = idex_q.pc;
    assign bus.out_rs1_data = idex_q.rs1_data;
    assign bus.out_rs2_data = idex_q.rs2_data;
    assign bus.out_imm      = idex_q.imm;
    assign bus.out_rd       = idex_q.rd;
    assign bus.out_we       = idex_q.we;
    assign bus.out_opclass  = idex_q.opclass;
    assign bus.out_funct3   = idex_q.funct3;
    assign bus.out_funct7b5 = idex_q.funct7b5;
    assign bus.out_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX entries are queued at issue and
// compared by a monitor whenever execute accepts an entry.
module tb_decode_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    idex_t exp_q[$];
    idex_t obs, exp_e;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            obs = '{pc: bus.out_pc, rs1_data: bus.out_rs1_data, rs2_data: bus.out_rs2_data,
                    imm: bus.out_imm, rd: bus.out_rd, we: bus.out_we,
                    opclass: opclass_t'(bus.out_opclass), funct3: bus.out_funct3,
                    funct7b5: bus.out_funct7b5, illegal: bus.out_illegal};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h expected no entry", obs);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs !== exp_e) begin
                    n_err++;
                    $display("FAIL idex_entry: got %h expected %h", obs, exp_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        bus.in_valid      = 1'b1;
        bus.in_instr      = ins;
        bus.in_pc         = pc;
        bus.rb_read_data1 = d1;
        bus.rb_read_data2 = d2;
    endtask

    // Queue the expected entry for the presented instruction, then let it issue.
    task automatic issue(input string name, input logic [XLEN-1:0] imm, input logic [4:0] rd,
                         input logic we, input opclass_t oc, input logic [2:0] f3,
                         input logic f7b5, input logic ill);
        idex_t e;
        e.pc = bus.in_pc;
        e.rs1_data = bus.rb_read_data1;
        e.rs2_data = bus.rb_read_data2;
        e.imm = imm;
        e.rd = rd;
        e.we = we;
        e.opclass = oc;
        e.funct3 = f3;
        e.funct7b5 = f7b5;
        e.illegal = ill;
        exp_q.push_back(e);
        @(negedge clk);
        chk({name, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
        chk({name, "_rb_instr"}, {32'd0, bus.rb_instruction}, {32'd0, bus.in_instr});
        chk({name, "_rb_en"}, {63'd0, bus.rb_read_en}, 64'd1);
        step();
        chk({name, "_latency"}, {63'd0, bus.out_valid}, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.rb_read_data1 = '0;
        bus.rb_read_data2 = '0;
        bus.wb_en = 1'b0;
        bus.wb_rd = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_pc", bus.out_pc, 64'd0);
        chk("rst_imm", bus.out_imm, 64'd0);
        chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        rst_n = 1'b1;

        // addi x1,x0,5
        present(32'h0050_0093, 64'h1000, 64'h0, 64'h55);
        issue("addi", 64'd5, 5'd1, 1'b1, OcOpimm, 3'd0, 1'b0, 1'b0);

        // add x2,x1,x1: stalls on x1, still stalled in the wb_en cycle
        present(32'h0010_8133, 64'h1004, 64'h0, 64'h0);
        @(negedge clk);
        chk("raw_stall", {63'd0, bus.in_ready}, 64'd0);
        step();
        bus.wb_en = 1'b1;
        bus.wb_rd = 5'd1;
        @(negedge clk);
        chk("wb_cycle_stall", {63'd0, bus.in_ready}, 64'd0);
        step();
        bus.wb_en = 1'b0;
        bus.rb_read_data1 = 64'd5;
        bus.rb_read_data2 = 64'd5;
        issue("add", 64'd0, 5'd2, 1'b1, OcOp, 3'd0, 1'b0, 1'b0);

        bus.wb_en = 1'b1;
        bus.wb_rd = 5'd2;
        step();
        bus.wb_en = 1'b0;

        // sw x3,-4(x2)
        present(32'hFE31_2E23, 64'h1008, 64'h2000, 64'h33);
        issue("sw", 64'hFFFF_FFFF_FFFF_FFFC, 5'd28, 1'b0, OcStore, 3'd2, 1'b1, 1'b0);
        // beq x28,x0,-8: issuing proves the store left sb[28] clear
        present(32'hFE0E_0CE3, 64'h100C, 64'h7, 64'h0);
        issue("beq", 64'hFFFF_FFFF_FFFF_FFF8, 5'd25, 1'b0, OcBranch, 3'd0, 1'b1, 1'b0);
        // jal x5,+2048
        present(32'h0010_02EF, 64'h1010, 64'h0, 64'h0);
        issue("jal", 64'h800, 5'd5, 1'b1, OcJal, 3'd0, 1'b0, 1'b0);

        // Backpressure, then flush of the held jal entry
        bus.out_ready = 1'b0;
        present(32'h0010_0393, 64'h1014, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_hold_imm", bus.out_imm, 64'h800);
            step();
        end
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        bus.flush = 1'b0;
        void'(exp_q.pop_front());
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.out_ready = 1'b1;

        // addi x6,x5,1: issues only if the flush cleared sb[5]
        present(32'h0012_8313, 64'h1018, 64'h800, 64'h0);
        issue("post_flush", 64'd1, 5'd6, 1'b1, OcOpimm, 3'd0, 1'b0, 1'b0);

        present(32'h0000_037F, 64'h101C, 64'h0, 64'h0);
        issue("illegal", 64'd0, 5'd6, 1'b0, OcIllegal, 3'd0, 1'b0, 1'b1);

        // add x8,x6,x0 stalls on x6; reset mid-stall with an entry held in ID/EX
        present(32'h0003_0433, 64'h1020, 64'h9, 64'h0);
        @(negedge clk);
        chk("stall_before_rst", {63'd0, bus.in_ready}, 64'd0);
        #1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("arst_imm", bus.out_imm, 64'd0);
        chk("arst_rd", {59'd0, bus.out_rd}, 64'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        issue("replay", 64'd0, 5'd8, 1'b1, OcOp, 3'd0, 1'b0, 1'b0);

        repeat (3) step();
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
